// File: rtl/memory_responder_if.sv
// Memory port between the datapath (initiator) and the memory responder.
// The initiator drives strobes, MAR address and MDR write data; the responder returns data and status.
interface memory_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output read, write, addr, data_in,
    input  data_out, done, busy, err
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, done, busy, err
  );
endinterface

// File: rtl/memory_responder.sv
// RAM model behind the MAR/MDR port: accept, WAIT_CYCLES wait states, then one-cycle done.
// Optional range checking of addr[31:ADDR_W] is enabled with MEM_BOUNDS_CHECK_EN.
module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                clr,
  memory_responder_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0]       mem [0:DEPTH-1];

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [31:0]       lat_data_reg;
  logic              lat_write_reg;
  logic              lat_oor_reg;
  logic [31:0]       data_out_reg;

  logic              accept;
  logic              enter_resp;
  logic              in_oor;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic              acc_write;
  logic              acc_oor;
  logic              mem_we;
  logic              mem_re;

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_oor = |bus.addr[31:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];
  assign in_oor         = 1'b0;
`endif

  // With zero wait states RESP is entered on the accept edge, so the access uses the live inputs.
  assign acc_addr  = (state_reg == S_IDLE) ? bus.addr[ADDR_W-1:0] : lat_addr_reg;
  assign acc_data  = (state_reg == S_IDLE) ? bus.data_in : lat_data_reg;
  assign acc_write = (state_reg == S_IDLE) ? bus.write : lat_write_reg;
  assign acc_oor   = (state_reg == S_IDLE) ? in_oor : lat_oor_reg;

  assign mem_we = enter_resp & acc_write & ~acc_oor;
  assign mem_re = enter_resp & ~acc_write;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.read || bus.write) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      lat_addr_reg  <= '0;
      lat_data_reg  <= 32'h0;
      lat_write_reg <= 1'b0;
      lat_oor_reg   <= 1'b0;
      data_out_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        lat_addr_reg  <= bus.addr[ADDR_W-1:0];
        lat_data_reg  <= bus.data_in;
        lat_write_reg <= bus.write;
        lat_oor_reg   <= in_oor;
      end
      if (mem_re)
        data_out_reg <= acc_oor ? 32'h0 : mem[acc_addr];
    end
  end

  // Array contents survive reset; the write is suppressed while clr is held.
  always_ff @(posedge clk) begin
    if (mem_we && !clr)
      mem[acc_addr] <= acc_data;
  end

  assign bus.data_out = data_out_reg;
  assign bus.done     = (state_reg == S_RESP);
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.err      = (state_reg == S_RESP) & lat_oor_reg;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: one instance with 2 wait states, one with none, checked against an array model.
module tb_memory_responder;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  memory_responder_if bus0 ();
  memory_responder_if bus1 ();

  memory_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(2)) u_dut (
    .clk (clk), .clr (clr), .bus (bus0.slave)
  );
  memory_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .clr (clr), .bus (bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word array per instance plus the last completed read.
  logic [31:0] m_mem   [2][512];
  bit          m_val   [2][512];
  logic [31:0] m_dout  [2];
  bit          m_known [2];

  function automatic bit oor(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return a[31:9] != 23'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_lat(input bit sel);
    return sel ? 1 : 3;
  endfunction

  function automatic logic cur_done(input bit sel); return sel ? bus1.done : bus0.done; endfunction
  function automatic logic cur_busy(input bit sel); return sel ? bus1.busy : bus0.busy; endfunction
  function automatic logic cur_err (input bit sel); return sel ? bus1.err  : bus0.err;  endfunction
  function automatic logic [31:0] cur_dout(input bit sel); return sel ? bus1.data_out : bus0.data_out; endfunction

  task automatic set_req(input bit sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bus1.read = rd; bus1.write = wr; bus1.addr = a; bus1.data_in = d;
    end else begin
      bus0.read = rd; bus0.write = wr; bus0.addr = a; bus0.data_in = d;
    end
  endtask

  task automatic model_txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output bit exp_err);
    exp_err = oor(a);
    if (wr) begin
      if (!exp_err) begin
        m_mem[sel][a[8:0]] = d;
        m_val[sel][a[8:0]] = 1'b1;
      end
    end else if (rd) begin
      if (exp_err) begin
        m_dout[sel] = 32'h0; m_known[sel] = 1'b1;
      end else begin
        m_dout[sel] = m_mem[sel][a[8:0]]; m_known[sel] = m_val[sel][a[8:0]];
      end
    end
  endtask

  // Drives one transaction, scrambling the inputs while busy, and returns what was seen in the done cycle.
  task automatic run_txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int bcyc, output logic [31:0] dout, output logic er);
    set_req(sel, rd, wr, a, d);
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0, $urandom, $urandom);
    lat = 1; bcyc = 0;
    while (cur_done(sel) !== 1'b1 && lat < 40) begin
      if (cur_busy(sel) === 1'b1) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (cur_busy(sel) === 1'b1) bcyc++;
    dout = cur_dout(sel);
    er   = cur_err(sel);
    $display("txn dut%0d rd=%0b wr=%0b addr=%h din=%h -> lat=%0d dout=%h err=%0b", sel, rd, wr, a, d, lat, dout, er);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    #12;
    n_checks++;
    if ({bus0.done, bus0.busy, bus0.err, bus0.data_out, bus1.done, bus1.busy, bus1.err, bus1.data_out} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h, want all zero", {bus0.done, bus0.busy, bus0.err, bus0.data_out},
               {bus1.done, bus1.busy, bus1.err, bus1.data_out});
    end
    @(posedge clk); #1;
    clr = 1'b0;
    m_dout[0] = 0; m_dout[1] = 0; m_known[0] = 1; m_known[1] = 1;
    $display("txn reset released");
  endtask

  task automatic test_abort();
    int lat, bcyc; logic [31:0] dout; logic er; bit ee; bit saw_done;
    model_txn(0, 0, 1, 5, 32'h11111111, ee);
    run_txn(0, 0, 1, 5, 32'h11111111, lat, bcyc, dout, er);
    set_req(0, 0, 1, 5, 32'hDEADBEEF);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    n_checks++;
    if ({bus0.busy, bus0.done, bus0.data_out} !== 34'h0) begin
      n_fail++; $display("FAIL abort_clear: busy/done/dout=%h want 0", {bus0.busy, bus0.done, bus0.data_out});
    end
    m_dout[0] = 0; m_dout[1] = 0; m_known[0] = 1; m_known[1] = 1;
    @(posedge clk); #1;
    clr = 1'b0;
    saw_done = 0;
    repeat (5) begin @(posedge clk); #1; if (bus0.done !== 1'b0) saw_done = 1; end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL abort_no_done: done pulsed after abort, want none"); end
    model_txn(0, 1, 0, 5, 0, ee);
    run_txn(0, 1, 0, 5, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h11111111) begin n_fail++; $display("FAIL abort_mem_kept: got %h want 11111111", dout); end
  endtask

  task automatic test_write_read();
    int lat, bcyc; logic [31:0] dout; logic er; bit ee;
    model_txn(0, 0, 1, 32'h10, 32'h12345678, ee);
    run_txn(0, 0, 1, 32'h10, 32'h12345678, lat, bcyc, dout, er);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
    n_checks++;
    if (dout !== m_dout[0]) begin n_fail++; $display("FAIL write_keeps_dout: got %h want %h", dout, m_dout[0]); end
    model_txn(0, 1, 0, 16, 0, ee);
    run_txn(0, 1, 0, 16, 0, lat, bcyc, dout, er);
    n_checks++;
    if (lat !== 3 || dout !== 32'h12345678) begin
      n_fail++; $display("FAIL read_back: lat=%0d dout=%h want 3/12345678", lat, dout);
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (bus0.data_out !== 32'h12345678) begin n_fail++; $display("FAIL dout_hold: got %h want 12345678", bus0.data_out); end
  endtask

  task automatic test_zero_wait();
    int lat, bcyc; logic [31:0] dout; logic er; bit ee;
    model_txn(1, 0, 1, 0, 32'hCAFEF00D, ee);
    run_txn(1, 0, 1, 0, 32'hCAFEF00D, lat, bcyc, dout, er);
    model_txn(1, 1, 0, 0, 0, ee);
    run_txn(1, 1, 0, 0, 0, lat, bcyc, dout, er);
    n_checks++;
    if (lat !== 1 || bcyc !== 1) begin n_fail++; $display("FAIL zero_wait_timing: lat=%0d busy=%0d want 1/1", lat, bcyc); end
    n_checks++;
    if (dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL zero_wait_data: got %h want cafef00d", dout); end
  endtask

  task automatic test_simultaneous();
    int lat, bcyc; logic [31:0] dout; logic er; bit ee;
    model_txn(0, 1, 1, 3, 32'hAA, ee);
    run_txn(0, 1, 1, 3, 32'hAA, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h12345678) begin n_fail++; $display("FAIL both_strobes_dout: got %h want 12345678", dout); end
    model_txn(0, 1, 0, 3, 0, ee);
    run_txn(0, 1, 0, 3, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'hAA) begin n_fail++; $display("FAIL both_strobes_write: got %h want 000000aa", dout); end
  endtask

  task automatic test_ignored_busy();
    int lat, bcyc, guard; logic [31:0] dout; logic er; bit ee;
    model_txn(0, 0, 1, 8, 32'h55, ee);
    run_txn(0, 0, 1, 8, 32'h55, lat, bcyc, dout, er);
    model_txn(0, 0, 1, 7, 32'h77, ee);
    set_req(0, 0, 1, 7, 32'h77);
    @(posedge clk); #1;
    set_req(0, 0, 1, 8, 32'hBAD);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    guard = 0;
    while (bus0.done !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (guard >= 20) begin n_fail++; $display("FAIL busy_ignore_done: done=%b want 1", bus0.done); end
    $display("txn dut0 write addr 7 with busy-time write to addr 8");
    @(posedge clk); #1;
    model_txn(0, 1, 0, 7, 0, ee);
    run_txn(0, 1, 0, 7, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h77) begin n_fail++; $display("FAIL busy_ignore_latched: got %h want 00000077", dout); end
    model_txn(0, 1, 0, 8, 0, ee);
    run_txn(0, 1, 0, 8, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h55) begin n_fail++; $display("FAIL busy_ignore_other: got %h want 00000055", dout); end
  endtask

  task automatic test_back_to_back();
    int guard; bit ee;
    model_txn(0, 1, 0, 3, 0, ee);
    model_txn(0, 1, 0, 16, 0, ee);
    set_req(0, 1, 0, 16, 0);
    @(posedge clk); #1;
    guard = 0;
    while (bus0.done !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    n_checks++;
    if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap: busy=%b want 0", bus0.busy); end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    n_checks++;
    if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL held_restart: busy=%b want 1", bus0.busy); end
    guard = 0;
    while (bus0.done !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (bus0.data_out !== 32'h12345678) begin n_fail++; $display("FAIL held_data: got %h want 12345678", bus0.data_out); end
    $display("txn dut0 held read strobe, two reads of addr 16");
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int lat, bcyc; logic [31:0] dout; logic er; bit ee;
    model_txn(0, 0, 1, 5, 32'h0BADF00D, ee);
    run_txn(0, 0, 1, 5, 32'h0BADF00D, lat, bcyc, dout, er);
    model_txn(0, 0, 1, 32'h205, 32'hFEEDFACE, ee);
    run_txn(0, 0, 1, 32'h205, 32'hFEEDFACE, lat, bcyc, dout, er);
    model_txn(0, 1, 0, 5, 0, ee);
    n_checks++;
`ifdef MEM_BOUNDS_CHECK_EN
    if (er !== 1'b1 || lat !== 3) begin n_fail++; $display("FAIL oor_write_err: err=%b lat=%0d want 1/3", er, lat); end
    run_txn(0, 1, 0, 5, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h0BADF00D) begin n_fail++; $display("FAIL oor_write_blocked: got %h want 0badf00d", dout); end
    model_txn(0, 1, 0, 32'h205, 0, ee);
    run_txn(0, 1, 0, 32'h205, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL oor_read: dout=%h err=%b want 0/1", dout, er); end
`else
    if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_write_err: err=%b want 0", er); end
    run_txn(0, 1, 0, 5, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'hFEEDFACE) begin n_fail++; $display("FAIL wrap_write: got %h want feedface", dout); end
    model_txn(0, 1, 0, 32'h205, 0, ee);
    run_txn(0, 1, 0, 32'h205, 0, lat, bcyc, dout, er);
    n_checks++;
    if (dout !== 32'hFEEDFACE || er !== 1'b0) begin n_fail++; $display("FAIL wrap_read: dout=%h err=%b want feedface/0", dout, er); end
`endif
  endtask

  task automatic test_random();
    int lat, bcyc; logic [31:0] dout, a, d; logic er; bit ee, sel, rd, wr;
    for (int i = 0; i < 150; i++) begin
      sel = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 7)) << 9);
      d   = $urandom;
      wr  = 1'($urandom_range(0, 1));
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      model_txn(sel, rd, wr, a, d, ee);
      run_txn(sel, rd, wr, a, d, lat, bcyc, dout, er);
      n_checks++;
      if (lat !== exp_lat(sel) || bcyc !== exp_lat(sel) || er !== ee) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d busy=%0d err=%b want %0d/%0d/%b", i, lat, bcyc, er, exp_lat(sel), exp_lat(sel), ee);
      end
      if (m_known[sel]) begin
        n_checks++;
        if (dout !== m_dout[sel]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, dout, m_dout[sel]); end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) for (int w = 0; w < 512; w++) m_val[s][w] = 1'b0;
    test_reset();
    test_abort();
    test_write_read();
    test_zero_wait();
    test_simultaneous();
    test_ignored_busy();
    test_back_to_back();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory port.
- Accepts read or write strobes with a 32-bit address (from MAR) and write data (from MDR).
- Inserts a programmable number of wait states, then returns read data for MDR's memory-data input and raises a one-cycle done pulse.
- Acts as the RAM chip the datapath talks to; the datapath/control unit is the initiator.

Parameters:
- ADDR_W, 9, number of address bits used to index the memory array.
- DEPTH, 512, number of 32-bit words; must equal 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between accept and done (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- read  input  1  read request strobe; level, sampled only in IDLE.
- write  input  1  write request strobe; level, sampled only in IDLE.
- addr  input  32  word address (MAR_out).
- data_in  input  32  write data (MDR_out).
- data_out  output  32  read data to MDR memory-data input.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high whenever the FSM is not in IDLE.
- err  output  1  range-error flag; see Optional Feature.

Behaviour:
- Reset (clr high, asynchronous): state=IDLE, wait counter=0, done=0, busy=0, err=0, data_out=32'h00000000.
  - Memory array contents are not cleared.
  - A transaction in flight when clr rises is aborted: no write, no done.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with read or write high, latch addr[ADDR_W-1:0], data_in and the operation type.
  - If both read and write are high, write has priority; no read data is returned.
  - Go to WAIT with counter=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
  - Without a request, stay in IDLE.
- WAIT: decrement the counter each cycle; when the counter is 0, go to RESP on the next edge.
- Entering RESP (same edge):
  - Write: mem[latched_addr] <= latched_data.
  - Read: data_out <= mem[latched_addr].
- RESP: done=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: done is high in the cycle starting WAIT_CYCLES+1 edges after the accepting edge (default: 3 edges).
- data_out is valid while done=1 and holds its value until the next completed read. Writes do not alter data_out.
- Strobes and addr/data_in changes are ignored while busy. Only values latched at accept are used.
- The initiator must drop its strobe in the done cycle. A strobe still high in the first IDLE cycle after RESP starts a new transaction.
- Read after write to the same address returns the newly written value; there is no bypass hazard because the transactions are serialized.
- Address handling: addr bits [31:ADDR_W] are ignored, so addresses wrap modulo DEPTH, unless the optional feature below is enabled.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- With the macro:
  - At accept, if addr[31:ADDR_W] is nonzero, the transaction is flagged out of range.
  - A flagged write does not modify memory.
  - A flagged read loads data_out=32'h00000000.
  - err=1 in the same cycle as done, for one cycle only.
  - Timing is unchanged.
- Without the macro: err is tied to 0 and addresses wrap as described.

Test Plan:
- Reset: assert clr mid-WAIT of a write of 32'hDEADBEEF to addr 5 -> done never pulses, busy=0 and data_out=0 immediately, a later read of addr 5 returns its pre-existing value.
- Write then read: write 32'h12345678 to addr 9'h010 (WAIT_CYCLES=2) -> done exactly 3 edges after accept. Read addr 16 -> data_out=32'h12345678 with done; data_out holds after done.
- Zero wait: WAIT_CYCLES=0, read addr 0 -> done asserted 1 edge after accept, busy high for exactly 1 cycle.
- Simultaneous strobes: read=write=1, addr 3, data_in 32'h000000AA -> memory[3]=32'hAA, data_out unchanged from the previous read.
- Ignored input while busy: change addr and pulse write during WAIT -> no effect. A strobe held high through done -> a second transaction starts in the next IDLE cycle.
- Out-of-range addr 32'h00000205:
  - Without macro: accesses word 5.
  - With MEM_BOUNDS_CHECK_EN: err=1 with done, a read returns 0, and word 5 is untouched by a write.
